regfile_pc: RTL and testbench

Parametrised successor to the 8x8 processor register file: configurable width and depth, two combinational read ports, one synchronous write port, and a sequential hardware-clear engine that zeroes every entry after reset or on request. Sits in the datapath between decode (register pointers) and the ALU / writeback mux. It reports clear progress through `Busy` so the controller stalls issue until the file is valid.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_clr_seq.sv | 58 +++++
 rtl/regfile_pc.sv | 68 ++++++
 tb/tb_regfile_pc.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the processor register file.
package regfile_pkg;

  typedef enum logic {CLEAR, IDLE} rf_state_t;

  localparam int unsigned RF_W = 8;
  localparam int unsigned RF_D = 8;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear engine for regfile_pc: CLEAR/IDLE FSM and sweep pointer.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned D = RF_D,
  localparam int unsigned AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          Rst_n,
  input  logic          Clr,
  output logic          Busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(D - 1);

  rf_state_t     state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state <= CLEAR;
      // The reset edge zeroes entry 0 in the array, so the sweep resumes at entry 1.
      ptr   <= AW'(1);
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      CLEAR: begin
        if (ptr == LAST) begin
          state_nx = IDLE;
          ptr_nx   = '0;
        end else begin
          ptr_nx = ptr + AW'(1);
        end
      end
      IDLE: begin
        if (Clr) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      default: ;
    endcase
  end

  assign Busy     = (state == CLEAR);
  assign clr_we   = (state == CLEAR);
  assign clr_addr = ptr;

endmodule

// File: rtl/regfile_pc.sv
// Parametrised register file: 2 combinational reads, 1 sync write, hardware clear.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_pc
  import regfile_pkg::*;
#(
  parameter int unsigned W = RF_W,
  parameter int unsigned D = RF_D,
  parameter bit R0_ZERO = 1'b0,
  localparam int unsigned AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          Rst_n,
  input  logic          Clr,
  input  logic          Wen,
  input  logic [AW-1:0] Wd,
  input  logic [W-1:0]  Wdat,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  output logic [W-1:0]  RdatA,
  output logic [W-1:0]  RdatB,
  output logic          Busy
);

  logic [W-1:0]  core [D];
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          wr_ok;

  regfile_clr_seq #(.D(D)) u_clr_seq (
    .clk      (clk),
    .Rst_n    (Rst_n),
    .Clr      (Clr),
    .Busy     (Busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A pointer is usable if it lands inside the array and is not the hard-wired zero entry.
  function automatic logic ptr_ok(input logic [AW-1:0] p);
    return (32'(p) < D) && !(R0_ZERO && (p == '0));
  endfunction

  assign wr_ok = Wen && !Busy && ptr_ok(Wd);

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      core[0] <= '0;
    end else if (clr_we) begin
      core[clr_addr] <= '0;
    end else if (wr_ok) begin
      core[Wd] <= Wdat;
    end
  end

  always_comb begin
    RdatA = '0;
    RdatB = '0;
    if (!Busy) begin
      if (ptr_ok(Ra)) RdatA = core[Ra];
      if (ptr_ok(Rb)) RdatB = core[Rb];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (Wd == Ra)) RdatA = Wdat;
      if (wr_ok && (Wd == Rb)) RdatB = Wdat;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_pc.sv
// Self-checking bench for regfile_pc (D=8): vector table plus clear/reset sequences.
module tb_regfile_pc;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, clr, wen;
  logic [2:0] wd, ra, rb;
  logic [7:0] wdat;
  logic [7:0] rda, rdb, zda, zdb;
  logic       busy, zbusy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_pc #(.W(8), .D(8), .R0_ZERO(1'b0)) dut (
    .clk(clk), .Rst_n(rst_n), .Clr(clr), .Wen(wen), .Wd(wd), .Wdat(wdat),
    .Ra(ra), .Rb(rb), .RdatA(rda), .RdatB(rdb), .Busy(busy)
  );

  regfile_pc #(.W(8), .D(8), .R0_ZERO(1'b1)) dut_z (
    .clk(clk), .Rst_n(rst_n), .Clr(clr), .Wen(wen), .Wd(wd), .Wdat(wdat),
    .Ra(ra), .Rb(rb), .RdatA(zda), .RdatB(zdb), .Busy(zbusy)
  );

  typedef struct {
    string      nm;
    logic [7:0] a, b;
    logic       busy;
    logic [7:0] za, zb;
  } exp_t;

  typedef struct {
    string      nm;
    logic       wen;
    logic [2:0] wd;
    logic [7:0] wdat;
    logic [2:0] ra, rb;
    logic [7:0] ea, eb;   // expected without forwarding
    logic [7:0] ba, bb;   // expected with forwarding
  } vec_t;

  exp_t sbq[$];
  exp_t cur;
  vec_t vq[$];

  function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      cur = sbq.pop_front();
      chk({cur.nm, ".busy"},   {7'b0, busy},  {7'b0, cur.busy});
      chk({cur.nm, ".busy_z"}, {7'b0, zbusy}, {7'b0, cur.busy});
      chk({cur.nm, ".RdatA"},  rda, cur.a);
      chk({cur.nm, ".RdatB"},  rdb, cur.b);
      chk({cur.nm, ".RdatA_z"}, zda, cur.za);
      chk({cur.nm, ".RdatB_z"}, zdb, cur.zb);
    end
  end

  // Drive one cycle of inputs and queue what both instances must show before the next edge.
  task automatic step(input logic r, input logic c, input logic w, input logic [2:0] pwd,
                      input logic [7:0] pwdat, input logic [2:0] pra, input logic [2:0] prb,
                      input string nm, input logic [7:0] ea, input logic [7:0] eb,
                      input logic eby);
    exp_t e;
    rst_n = r; clr = c; wen = w; wd = pwd; wdat = pwdat; ra = pra; rb = prb;
    e.nm   = nm;
    e.a    = ea;
    e.b    = eb;
    e.busy = eby;
    e.za   = (pra == 3'd0) ? 8'h00 : ea;
    e.zb   = (prb == 3'd0) ? 8'h00 : eb;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic void addv(input string nm, input logic w, input logic [2:0] pwd,
                               input logic [7:0] pwdat, input logic [2:0] pra,
                               input logic [2:0] prb, input logic [7:0] ea,
                               input logic [7:0] eb, input logic [7:0] ba,
                               input logic [7:0] bb);
    vec_t v;
    v.nm = nm; v.wen = w; v.wd = pwd; v.wdat = pwdat; v.ra = pra; v.rb = prb;
    v.ea = ea; v.eb = eb; v.ba = ba; v.bb = bb;
    vq.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    addv("w3_same", 1, 3'd3, 8'hA5, 3'd3, 3'd3, 8'h00, 8'h00, 8'hA5, 8'hA5);
    addv("r3_both", 0, 3'd0, 8'h00, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    addv("r2_r3",   0, 3'd0, 8'h00, 3'd2, 3'd3, 8'h00, 8'hA5, 8'h00, 8'hA5);
    addv("byp_r5",  1, 3'd5, 8'h3C, 3'd5, 3'd3, 8'h00, 8'hA5, 8'h3C, 8'hA5);
    addv("r5_both", 0, 3'd0, 8'h00, 3'd5, 3'd5, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
    addv("w_r0",    1, 3'd0, 8'h5A, 3'd0, 3'd0, 8'h00, 8'h00, 8'h5A, 8'h5A);
    addv("r0_r1",   0, 3'd0, 8'h00, 3'd0, 3'd1, 8'h5A, 8'h00, 8'h5A, 8'h00);
    addv("byp_b6",  1, 3'd6, 8'h77, 3'd7, 3'd6, 8'h00, 8'h00, 8'h00, 8'h77);
    addv("r6_r3",   0, 3'd0, 8'h00, 3'd6, 3'd3, 8'h77, 8'hA5, 8'h77, 8'hA5);

    rst_n = 1'b0; clr = 1'b0; wen = 1'b0; wd = '0; wdat = '0; ra = '0; rb = '0;
    @(posedge clk);
    #1;

    repeat (2) step(0, 0, 0, 3'd0, 8'h00, 3'd0, 3'd0, "rst_hold", 8'h00, 8'h00, 1);

    // Release: 7 busy cycles; a write to r4 and a Clr pulse land mid-sweep and are ignored.
    for (int i = 0; i < 7; i++)
      step(1, (i == 3), (i == 2), 3'd4, 8'hFF, 3'd4, 3'd4, "rst_sweep", 8'h00, 8'h00, 1);

    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 3'd0, 8'h00, 3'(i), 3'(7 - i), "post_rst", 8'h00, 8'h00, 0);

    for (int i = 0; i < vq.size(); i++)
      step(1, 0, vq[i].wen, vq[i].wd, vq[i].wdat, vq[i].ra, vq[i].rb, vq[i].nm,
           BYP ? vq[i].ba : vq[i].ea, BYP ? vq[i].bb : vq[i].eb, 0);

    // Fill r0..r7 with 0x11..0x88, reading back the previously written entry.
    for (int i = 0; i < 8; i++)
      step(1, 0, 1, 3'(i), 8'((i + 1) * 17), (i == 0) ? 3'd1 : 3'(i - 1),
           (i == 0) ? 3'd1 : 3'(i - 1), "fill",
           (i == 0) ? 8'h00 : 8'(i * 17), (i == 0) ? 8'h00 : 8'(i * 17), 0);

    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 3'd0, 8'h00, 3'(i), 3'(7 - i), "fill_rd",
           8'((i + 1) * 17), 8'((8 - i) * 17), 0);

    // Clr together with a write to r1: the write lands, then the sweep clears it.
    step(1, 1, 1, 3'd1, 8'hEE, 3'd2, 3'd5, "clr_req", 8'h33, 8'h66, 0);
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 3'd0, 8'h00, 3'd1, 3'd6, "clr_busy", 8'h00, 8'h00, 1);
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 3'd0, 8'h00, 3'(i), 3'(7 - i), "post_clr", 8'h00, 8'h00, 0);

    // Reset asserted in the 4th cycle of a sweep restarts it.
    step(1, 0, 1, 3'd6, 8'h66, 3'd5, 3'd5, "w6", 8'h00, 8'h00, 0);
    step(1, 0, 0, 3'd0, 8'h00, 3'd6, 3'd6, "r6", 8'h66, 8'h66, 0);
    step(1, 1, 0, 3'd0, 8'h00, 3'd6, 3'd6, "clr2_req", 8'h66, 8'h66, 0);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 3'd0, 8'h00, 3'd6, 3'd6, "clr2_busy", 8'h00, 8'h00, 1);
    step(0, 0, 0, 3'd0, 8'h00, 3'd6, 3'd6, "mid_rst", 8'h00, 8'h00, 1);
    for (int i = 0; i < 7; i++)
      step(1, 0, 0, 3'd0, 8'h00, 3'd6, 3'd6, "restart", 8'h00, 8'h00, 1);
    step(1, 0, 0, 3'd0, 8'h00, 3'd6, 3'd6, "r6_cleared", 8'h00, 8'h00, 0);
    step(1, 0, 0, 3'd0, 8'h00, 3'd2, 3'd7, "r2_r7_cleared", 8'h00, 8'h00, 0);

    for (int k = 0; k < 4 && sbq.size() != 0; k++) @(negedge clk);
    #1;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
